change_notify: RTL and testbench
================================

CHANGE_NOTIFY -- requirements
Module: change_notify

Interface
REQ-001 SHALL have parameter WID, default 32, width of monitored value.
REQ-002 SHALL have parameter DEPTH, default 4, pending-change queue entries (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ce  input  1  clock enable for sampling i.
REQ-006 SHALL have port i  input  WID  monitored value.
REQ-007 SHALL have port o_valid  output  1  queue head holds a change record.
REQ-008 SHALL have port o_ready  input  1  consumer accepts head this cycle.
REQ-009 SHALL have port o_dat  output  WID  value of the oldest unconsumed change.
REQ-010 SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-011 SHALL have port ovf  output  1  sticky: a change was coalesced because the queue was full.

Function
REQ-012 SHALL keep a hold register and a two-state arming FSM: UNPRIMED, ARMED.
REQ-013 In UNPRIMED, a ce cycle SHALL load hold<=i, go to ARMED, and generate no event.
REQ-014 In ARMED, a ce cycle with i!=hold SHALL be a change event: hold<=i, i pushed to queue.
REQ-015 ce low or i==hold SHALL generate no event; hold unchanged.
REQ-016 o_valid SHALL equal (count!=0); o_dat SHALL be the head entry; pop occurs when o_valid&o_ready.
REQ-017 Latency: event in cycle N SHALL show o_valid=1 with that value at cycle N+1 when the queue was empty.
REQ-018 o_dat SHALL stay stable while o_valid=1 and o_ready=0.
REQ-019 Queue full, event, no pop: newest entry SHALL be overwritten with i (latest value wins), count unchanged, ovf<=1.
REQ-020 Queue full, event and pop in the same cycle: push SHALL succeed normally, ovf unchanged.
REQ-021 Push and pop in the same cycle on a non-full queue: count SHALL be unchanged.
REQ-022 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-023 ovf SHALL remain set until clr_ovf; when clr_ovf and a new overflow coincide, set SHALL win.
REQ-024 o_ready with o_valid=0 SHALL be ignored.

Reset
REQ-025 rst SHALL asynchronously force FSM=UNPRIMED, hold=0, pointers=0, count=0, ovf=0, o_valid=0.
REQ-026 Reset mid-operation SHALL discard all queued changes; the first ce after release primes without an event.

Configuration
REQ-027 With CHANGE_NOTIFY_TSTAMP_EN defined, SHALL add output o_ts [15:0], a free-running clk counter (reset 0, wraps 16'hFFFF->0) captured with each pushed entry and presented alongside o_dat; overwrite on overflow SHALL also replace its timestamp.
REQ-028 Without CHANGE_NOTIFY_TSTAMP_EN, o_ts, the counter and timestamp storage SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package change_notify_pkg SHALL hold the DEPTH default, TS_WID=16, and the FSM state typedef.
REQ-030 Queue storage and pointers SHALL be in sub-module change_notify_fifo (push, pop, overwrite-last, full, empty, count).

Verification
REQ-031 Reset, ce=1, i=32'h5 held: no o_valid ever (priming only).
REQ-032 After priming at 5, i->32'hA with ce=1: next cycle o_valid=1, o_dat=32'hA; o_ready=1 -> o_valid=0.
REQ-033 o_ready=0, DEPTH=4, changes to 1,2,3,4,5: queue reads 1,2,3,5, ovf=1; clr_ovf -> ovf=0.
REQ-034 Full queue, change to 9 with o_ready=1 same cycle: no ovf, drain yields old entries 2-4 then 9.
REQ-035 i toggling with ce=0: no events; ce=1 with i==hold: no event.
REQ-036 rst pulse with 3 entries queued: o_valid=0 immediately; next change after re-prime is sole entry; with CHANGE_NOTIFY_TSTAMP_EN, o_ts equals counter value at push cycle.

Source files
------------

// File: rtl/change_notify_pkg.sv
// change_notify_pkg: shared constants and types for the change_notify block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: DEPTH_DEF (default queue depth), TS_WID (timestamp width),
//           arm_state_t (arming FSM state encoding).
package change_notify_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int TS_WID    = 16;

  typedef enum logic {
    UNPRIMED = 1'b0,
    ARMED    = 1'b1
  } arm_state_t;

endpackage

// File: rtl/change_notify_fifo.sv
// change_notify_fifo: circular queue of change records, with an overwrite-newest port.
// Latency: a push in cycle N is visible at rdat/count in cycle N+1.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
// Ports: clk, rst (async, active-high), push/pop/ovw (overwrite newest entry),
//        wdat, rdat (head entry), full, empty, count.
module change_notify_fifo
  import change_notify_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          ovw,
  input  logic [DW-1:0] wdat,
  output logic [DW-1:0] rdat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] last_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign rdat     = mem_q[rd_ptr_q];
  // Slot most recently written; pointers wrap naturally since DEPTH is a power of 2.
  assign last_ptr = wr_ptr_q - 1'b1;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && !empty;
    // A pop frees the head slot this cycle, so a full queue can still accept a push.
    do_push  = push && (!full || do_pop);

    if (do_push) begin
      mem_d[wr_ptr_q] = wdat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else if (ovw && !empty) begin
      mem_d[last_ptr] = wdat;
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset: entries are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/change_notify.sv
// change_notify: reports changes of a sampled value through a small queue; oldest change first.
// Latency: a change sampled in cycle N is presented at o_dat/o_valid in cycle N+1 (empty queue).
// Backpressure: o_ready low holds the head; on a full queue the newest entry is overwritten and ovf sets.
// Ports: clk, rst (async, active-high), ce, i (sampled value), o_valid/o_ready/o_dat (change
//        stream), clr_ovf/ovf (sticky overflow). Optional CHANGE_NOTIFY_TSTAMP_EN adds o_ts,
//        the free-running cycle counter value captured with each entry.
module change_notify
  import change_notify_pkg::*;
#(
  parameter int WID   = 32,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [WID-1:0]    i,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [WID-1:0]    o_dat,
  input  logic              clr_ovf,
`ifdef CHANGE_NOTIFY_TSTAMP_EN
  output logic [TS_WID-1:0] o_ts,
`endif
  output logic              ovf
);

`ifdef CHANGE_NOTIFY_TSTAMP_EN
  localparam int EW = WID + TS_WID;
`else
  localparam int EW = WID;
`endif

  arm_state_t     state_q, state_d;
  logic [WID-1:0] hold_q, hold_d;
  logic           ovf_q, ovf_d;
  logic           evt;
  logic           fifo_push, fifo_pop, fifo_ovw;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_cnt;
  logic [EW-1:0]  fifo_wdat, fifo_rdat;

`ifdef CHANGE_NOTIFY_TSTAMP_EN
  logic [TS_WID-1:0] ts_cnt_q, ts_cnt_d;

  assign ts_cnt_d  = ts_cnt_q + 1'b1;
  assign fifo_wdat = {ts_cnt_q, i};
  assign o_dat     = fifo_rdat[WID-1:0];
  assign o_ts      = fifo_rdat[EW-1:WID];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt_q <= '0;
    else     ts_cnt_q <= ts_cnt_d;
  end
`else
  assign fifo_wdat = i;
  assign o_dat     = fifo_rdat;
`endif

  assign o_valid = (fifo_cnt != '0);
  assign ovf     = ovf_q;

  // Arming FSM: the first enabled sample only primes the hold register.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    evt     = 1'b0;
    case (state_q)
      UNPRIMED: begin
        if (ce) begin
          hold_d  = i;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (ce && (i != hold_q)) begin
          evt    = 1'b1;
          hold_d = i;
        end
      end
      default: state_d = UNPRIMED;
    endcase
  end

  // A simultaneous pop makes room, so only an event on a full queue without a pop coalesces.
  always_comb begin
    fifo_pop  = o_ready && !fifo_empty;
    fifo_push = evt && (!fifo_full || fifo_pop);
    fifo_ovw  = evt && fifo_full && !fifo_pop;
    ovf_d     = ovf_q;
    if (clr_ovf)  ovf_d = 1'b0;
    if (fifo_ovw) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNPRIMED;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

  change_notify_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .ovw   (fifo_ovw),
    .wdat  (fifo_wdat),
    .rdat  (fifo_rdat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_change_notify.sv
// tb_change_notify: directed and random stimulus against a queue-based reference model.
// Stimulus applies inputs just after each rising edge and updates the model for that edge;
// a monitor at the falling edge checks o_valid/o_dat (and o_ts) against the expected queue.
module tb_change_notify;

  localparam int WID   = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] i = '0;
  logic        o_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        o_valid;
  logic [31:0] o_dat;
  logic        ovf;
`ifdef CHANGE_NOTIFY_TSTAMP_EN
  logic [15:0] o_ts;
`endif

  always #5 clk = ~clk;

  change_notify #(
    .WID   (WID),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .i       (i),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_dat   (o_dat),
    .clr_ovf (clr_ovf),
`ifdef CHANGE_NOTIFY_TSTAMP_EN
    .o_ts    (o_ts),
`endif
    .ovf     (ovf)
  );

  typedef struct {
    logic [31:0] v;
    logic [15:0] ts;
  } rec_t;

  // Reference model state: the list of pending changes, oldest first.
  rec_t        sb[$];
  rec_t        mon_r;
  bit          primed;
  logic [31:0] hold;
  bit          ovf_exp;
  logic [15:0] ts_cur;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: head must match the oldest pending change; a handshake retires it.
  always @(negedge clk) begin
    if (!rst) begin
      chk("o_valid", {63'd0, o_valid}, {63'd0, (sb.size() != 0)});
      if (o_valid && sb.size() != 0) begin
        mon_r = sb[0];
        chk("o_dat", {32'd0, o_dat}, {32'd0, mon_r.v});
`ifdef CHANGE_NOTIFY_TSTAMP_EN
        chk("o_ts", {48'd0, o_ts}, {48'd0, mon_r.ts});
`endif
        if (o_ready) sb.pop_front();
      end
    end
  end

  // Effect of one rising edge on the model; pops were already retired by the monitor.
  task automatic model_edge(input bit c, input logic [31:0] v, input bit clr);
    bit hit = 1'b0;
    if (c && !primed) begin
      primed = 1'b1;
      hold   = v;
    end else if (c && v != hold) begin
      hold = v;
      if (sb.size() == DEPTH) begin
        sb[sb.size()-1] = '{v, ts_cur};
        hit = 1'b1;
      end else begin
        sb.push_back('{v, ts_cur});
      end
    end
    if (clr) ovf_exp = 1'b0;
    if (hit) ovf_exp = 1'b1;
    ts_cur = ts_cur + 16'd1;
  endtask

  // Called just after a rising edge: drive one cycle, then account for the next edge.
  task automatic step(input bit c, input logic [31:0] v, input bit rdy, input bit clr);
    ce      = c;
    i       = v;
    o_ready = rdy;
    clr_ovf = clr;
    @(posedge clk);
    #1;
    model_edge(c, v, clr);
    chk("ovf", {63'd0, ovf}, {63'd0, ovf_exp});
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ce      = 1'b0;
    o_ready = 1'b0;
    clr_ovf = 1'b0;
    #1;
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    sb.delete();
    primed  = 1'b0;
    hold    = '0;
    ovf_exp = 1'b0;
    ts_cur  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit          rc, rr, rk;
    logic [31:0] rv;

    do_reset();

    // Priming only: a constant value never produces a change.
    repeat (5) step(1'b1, 32'h5, 1'b1, 1'b0);

    // Single change, one-cycle latency, then consumed.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b0, 32'hA, 1'b0, 1'b0);
    step(1'b0, 32'hA, 1'b1, 1'b0);
    step(1'b0, 32'hA, 1'b0, 1'b0);

    // Overflow: 1..5 with no consumer leaves 1,2,3,5 and sets ovf.
    for (int k = 1; k <= 5; k++) step(1'b1, 32'(k), 1'b0, 1'b0);
    chk("ovf_after_5", {63'd0, ovf}, 64'd1);
    step(1'b0, 32'h5, 1'b0, 1'b1);
    chk("ovf_cleared", {63'd0, ovf}, 64'd0);
    repeat (5) step(1'b0, 32'h5, 1'b1, 1'b0);

    // Full queue with a same-cycle pop: push succeeds, no overflow.
    for (int k = 1; k <= 4; k++) step(1'b1, 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'h9, 1'b1, 1'b0);
    chk("no_ovf_on_pop", {63'd0, ovf}, 64'd0);
    repeat (5) step(1'b0, 32'h9, 1'b1, 1'b0);

    // ce low suppresses sampling; equal value with ce high is not a change.
    for (int k = 0; k < 4; k++) step(1'b0, 32'h100 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'h9, 1'b0, 1'b0);
    step(1'b1, 32'h9, 1'b0, 1'b0);
    chk("no_evt_valid", {63'd0, o_valid}, 64'd0);

    // Reset with entries queued; re-prime, then a single change.
    for (int k = 1; k <= 3; k++) step(1'b1, 32'h20 + 32'(k), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 32'h7, 1'b0, 1'b0);
    step(1'b1, 32'h8, 1'b0, 1'b0);
    step(1'b0, 32'h8, 1'b0, 1'b0);
    step(1'b0, 32'h8, 1'b1, 1'b0);
    step(1'b0, 32'h8, 1'b0, 1'b0);

    // Random traffic with varying consumer pressure and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rc = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 5));
      if (n < 1000)      rr = ($urandom_range(0, 3) == 0);
      else if (n < 2000) rr = ($urandom_range(0, 1) == 0);
      else               rr = ($urandom_range(0, 3) != 0);
      rk = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(rc, rv, rr, rk);
    end

    repeat (DEPTH + 2) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("final_o_valid", {63'd0, o_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
